reg_write_queue: RTL and testbench
==================================

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2 or more.
REQ-002 SHALL have parameter AW, default 1: write address width.
REQ-003 SHALL have parameter DW, default 1: write data width.
REQ-004 SHALL provide one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port req_valid_in, input, 1 bit: write request valid.
REQ-008 SHALL have port req_addr_in, input, AW bits: request register address.
REQ-009 SHALL have port req_data_in, input, DW bits: request write data.
REQ-010 SHALL have port req_ready_out, output, 1 bit: queue can accept a request this cycle.
REQ-011 SHALL have port hold_in, input, 1 bit: suppress issue to the write port.
REQ-012 SHALL have port r_d_wen_out, output, 1 bit: write enable to the register file.
REQ-013 SHALL have port r_d_waddr_out, output, AW bits: write address to the register file.
REQ-014 SHALL have port d_out, output, DW bits: write data to the register file.
REQ-015 SHALL have port count_out, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-016 SHALL accept a request (push) on a rising edge with req_valid_in=1 and req_ready_out=1.
REQ-017 SHALL drive req_ready_out combinationally as (count_out != DEPTH); no push when full, even if a pop occurs in the same cycle.
REQ-018 SHALL pop the head entry on a rising edge when count_out != 0 and hold_in=0, at most one per cycle.
REQ-019 SHALL register the write-port outputs: on a pop edge, load head addr/data and set r_d_wen_out=1; on any other edge, set r_d_wen_out=0 and keep addr/data unchanged.
REQ-020 SHALL issue writes in strict acceptance order; same-address writes are not merged.
REQ-021 SHALL leave count_out unchanged on a simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-023 SHALL give, without bypass, a latency of 2 edges from push to the r_d_wen_out=1 cycle when empty and unheld.
REQ-024 SHALL make hold_in=1 force r_d_wen_out=0 on the next edge; held entries stay queued, and pushes continue until full.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear the pointers, count_out=0, r_d_wen_out=0, r_d_waddr_out=0 and d_out=0.
REQ-026 SHALL make reset assertion mid-operation flush all queued entries, with no write issued after reset release.
REQ-027 SHALL show req_ready_out=1 during and immediately after reset.

Configuration
REQ-028 SHALL use macro REG_WRITE_QUEUE_BYPASS_EN to select the bypass path.
REQ-029 SHALL, when REG_WRITE_QUEUE_BYPASS_EN is defined and count_out=0, hold_in=0 and a push occurs, load the request directly into the write-port outputs with r_d_wen_out=1 next cycle (latency 1), storing nothing and leaving count_out at 0.
REQ-030 SHALL, when REG_WRITE_QUEUE_BYPASS_EN is undefined, route every request through the FIFO per REQ-023.

Structure
REQ-031 SHALL place default AW/DW/DEPTH constants and the request struct type (addr, data) in shared package reg_file_pkg.
REQ-032 SHALL contain the storage in one sub-module, reg_wq_fifo (push/pop/count/full/empty); issue and bypass logic stay in the top level.

Verification
REQ-033 SHALL cover single write: push (addr=1, data=1) into an empty, unheld queue -> r_d_wen_out=1, r_d_waddr_out=1, d_out=1 exactly 2 cycles later (1 with bypass), then wen=0.
REQ-034 SHALL cover fill: hold_in=1, push 4 requests -> count_out=4, req_ready_out=0, a 5th valid is not accepted; release hold -> 4 consecutive wen pulses in push order.
REQ-035 SHALL cover wrap: 10 back-to-back pushes with hold_in=0 -> 10 writes in order, count_out never exceeds 2.
REQ-036 SHALL cover simultaneous push and pop at count_out=2 -> count_out stays 2, and order is preserved across the pointer wrap.
REQ-037 SHALL cover reset mid-queue: 3 entries held, reset=0 for 1 cycle -> count_out=0, all outputs 0, and no wen after release.
REQ-038 SHALL cover hold toggle: alternate hold_in every cycle with 4 queued -> wen only in cycles following hold_in=0, and all 4 delivered.

Source files
------------

// File: rtl/reg_write_queue_pkg.sv
// Shared constants and request type for the register write queue.
package reg_file_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 1;
  localparam int DEFAULT_DW    = 1;

  typedef struct packed {
    logic [DEFAULT_AW-1:0] addr;
    logic [DEFAULT_DW-1:0] data;
  } req_t;

endpackage

// File: rtl/reg_write_queue_if.sv
// Bundles the request handshake and the register-file write port of reg_write_queue.
// A request transfers on a rising edge where req_valid and req_ready are both 1;
// req_addr/req_data must be stable while req_valid is 1, and req_ready depends only on occupancy.
interface reg_write_queue_if #(
  parameter int AW = 1,
  parameter int DW = 1,
  parameter int CW = 3
);

  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          hold;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] count;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wen, waddr, wdata, count
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wen, waddr, wdata, count
  );

endinterface

// File: rtl/reg_write_queue_fifo.sv
// Circular-buffer storage for queued register writes: push/pop/count/full/empty.
module reg_wq_fifo
  import reg_file_pkg::*;
#(
  parameter int  DEPTH   = DEFAULT_DEPTH,
  parameter type entry_t = req_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  entry_t                       push_entry,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_entry;
  end

endmodule

// File: rtl/reg_write_queue.sv
// In-order register write queue with a registered write port and hold control.
// Define REG_WRITE_QUEUE_BYPASS_EN to let a request skip the empty queue (latency 1).
module reg_write_queue
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid_in,
  input  logic [AW-1:0]              req_addr_in,
  input  logic [DW-1:0]              req_data_in,
  output logic                       req_ready_out,
  input  logic                       hold_in,
  output logic                       r_d_wen_out,
  output logic [AW-1:0]              r_d_waddr_out,
  output logic [DW-1:0]              d_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t req_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   accept;
  logic   bypass;
  logic   push;
  logic   pop;

  assign req_entry     = '{addr: req_addr_in, data: req_data_in};
  assign req_ready_out = !fifo_full;
  assign accept        = req_valid_in && req_ready_out;

`ifdef REG_WRITE_QUEUE_BYPASS_EN
  // An empty, unheld queue forwards the request straight to the write port.
  assign bypass = accept && fifo_empty && !hold_in;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  assign pop  = !fifo_empty && !hold_in;

  reg_wq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .push       (push),
    .push_entry (req_entry),
    .pop        (pop),
    .head       (head),
    .count      (count_out),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Pop and bypass are mutually exclusive: bypass needs an empty queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_wen_out   <= 1'b0;
      r_d_waddr_out <= '0;
      d_out         <= '0;
    end else if (pop) begin
      r_d_wen_out   <= 1'b1;
      r_d_waddr_out <= head.addr;
      d_out         <= head.data;
    end else if (bypass) begin
      r_d_wen_out   <= 1'b1;
      r_d_waddr_out <= req_addr_in;
      d_out         <= req_data_in;
    end else begin
      r_d_wen_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: reset, single write, fill, wrap, push+pop, flush, hold toggle.
module tb_reg_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_write_queue_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  reg_write_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .req_valid_in  (bus.req_valid),
    .req_addr_in   (bus.req_addr),
    .req_data_in   (bus.req_data),
    .req_ready_out (bus.req_ready),
    .hold_in       (bus.hold),
    .r_d_wen_out   (bus.wen),
    .r_d_waddr_out (bus.waddr),
    .d_out         (bus.wdata),
    .count_out     (bus.count)
  );

  logic [AW+DW-1:0] exp_q[$];
  int n_total  = 0;
  int n_pass   = 0;
  int n_writes = 0;
  int max_cnt  = 0;
  int w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    exp_q.push_back({a, d});
  endtask

  task automatic send_unqueued(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  // Advance one edge, then score any write issued on it against the expected queue.
  task automatic step();
    @(posedge clk);
    #1;
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    if (bus.wen === 1'b1) begin
      n_writes++;
      chk("wen_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("wr_order", {bus.waddr, bus.wdata}, exp_q.pop_front());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.hold = 1'b0;
    idle();
    step();
    step();
    chk("rst_count", bus.count, 0);
    chk("rst_wen",   bus.wen,   0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_ready", bus.req_ready, 1);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", bus.req_ready, 1);

    // Single write into an empty, unheld queue.
    send(4'h1, 8'h01);
    step();
    idle();
`ifdef REG_WRITE_QUEUE_BYPASS_EN
    chk("single_wen",   bus.wen,   1);
    chk("single_count", bus.count, 0);
    chk("single_addr",  bus.waddr, 4'h1);
    chk("single_data",  bus.wdata, 8'h01);
    step();
    chk("single_wen_off", bus.wen, 0);
`else
    chk("single_wen_early", bus.wen,   0);
    chk("single_count1",    bus.count, 1);
    step();
    chk("single_wen",   bus.wen,   1);
    chk("single_addr",  bus.waddr, 4'h1);
    chk("single_data",  bus.wdata, 8'h01);
    chk("single_count", bus.count, 0);
    step();
    chk("single_wen_off", bus.wen, 0);
`endif

    // Fill while held; fifth request must be refused.
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(4'(2 + i), 8'(8'h20 + i));
      #0;
      chk("fill_ready", bus.req_ready, 1);
      step();
    end
    idle();
    chk("fill_count", bus.count, 4);
    chk("fill_full_ready", bus.req_ready, 0);
    send_unqueued(4'hF, 8'hFF);
    step();
    idle();
    chk("fill_5th_count", bus.count, 4);
    chk("fill_held_wen",  bus.wen,   0);
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_wen",   bus.wen,   1);
      chk("fill_addr",  bus.waddr, 4'(2 + i));
      chk("fill_count_drain", bus.count, 3 - i);
    end
    step();
    chk("fill_drained_wen", bus.wen, 0);

    // Ten back-to-back pushes with repeated addresses.
    max_cnt = 0;
    w0      = n_writes;
    for (int i = 0; i < 10; i++) begin
      send(4'(i % 3), 8'(8'h40 + i));
      step();
    end
    idle();
    step();
    step();
    chk("wrap_writes", n_writes - w0, 10);
    chk("wrap_max_le2", max_cnt <= 2, 1);
    chk("wrap_count", bus.count, 0);

    // Simultaneous push and pop at occupancy 2.
    bus.hold = 1'b1;
    send(4'hA, 8'hA0);
    step();
    send(4'hB, 8'hB1);
    step();
    chk("sim_count_pre", bus.count, 2);
    bus.hold = 1'b0;
    send(4'hC, 8'hC2);
    step();
    chk("sim_count_a", bus.count, 2);
    chk("sim_wen_a",   bus.wen,   1);
    chk("sim_addr_a",  bus.waddr, 4'hA);
    send(4'hD, 8'hD3);
    step();
    chk("sim_count_b", bus.count, 2);
    chk("sim_addr_b",  bus.waddr, 4'hB);
    idle();
    step();
    chk("sim_addr_c",  bus.waddr, 4'hC);
    chk("sim_count_c", bus.count, 1);
    step();
    chk("sim_addr_d",  bus.waddr, 4'hD);
    chk("sim_count_d", bus.count, 0);
    step();
    chk("sim_wen_off", bus.wen, 0);

    // Reset mid-queue flushes held entries.
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_unqueued(4'(5 + i), 8'(8'h50 + i));
      step();
    end
    idle();
    chk("rm_count_pre", bus.count, 3);
    rst_n = 1'b0;
    #1;
    chk("rm_count", bus.count, 0);
    chk("rm_wen",   bus.wen,   0);
    chk("rm_waddr", bus.waddr, 0);
    chk("rm_wdata", bus.wdata, 0);
    chk("rm_ready", bus.req_ready, 1);
    step();
    rst_n    = 1'b1;
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rm_no_wen",   bus.wen,   0);
      chk("rm_count_post", bus.count, 0);
    end

    // Hold toggling every cycle with four queued.
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(4'(8 + i), 8'(8'h80 + i));
      step();
    end
    idle();
    chk("ht_count_pre", bus.count, 4);
    for (int k = 0; k < 8; k++) begin
      bus.hold = k[0];
      step();
      chk("ht_wen",   bus.wen,   (k % 2) == 0);
      chk("ht_count", bus.count, 4 - (k / 2 + 1));
    end
    bus.hold = 1'b0;

    chk("final_q_empty", exp_q.size(), 0);
    chk("total_writes",  n_writes,     23);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
